// File: rtl/instrq_extra_rdctl.sv
// Read-side controller for the dual-thread instruction-queue extra-data FIFO: mirrors per-thread
// occupancy, schedules the read thread and stages the two head entries for the decode/rename consumer.
`ifndef instrQExtra_width
`define instrQExtra_width 32
`endif

module instrq_extra_rdctl #(
    parameter int DATA_WIDTH   = `instrQExtra_width,
    parameter int SWITCH_BURST = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  except,
    input  logic                  except_thread,
    input  logic                  wr_wen,
    input  logic                  wr_thread,
    input  logic [4:0]            wr_cnt,
    input  logic                  wr_fStall,
    input  logic                  wr_doFStall,
    output logic                  read_thread,
    output logic [2:0]            read_cnt,
    output logic                  stall,
    input  logic [DATA_WIDTH-1:0] rd_data0,
    input  logic [DATA_WIDTH-1:0] rd_data1,
    output logic [1:0]            out_valid,
    output logic                  out_thread,
    output logic [DATA_WIDTH-1:0] out_data0,
    output logic [DATA_WIDTH-1:0] out_data1,
    input  logic                  out_ready,
    output logic                  dbg_state,
    output logic [4:0]            dbg_occ0,
    output logic [4:0]            dbg_occ1
);

    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [2:0] BURST_MAX = 3'(SWITCH_BURST - 1);

    state_t                state_q;
    logic                  cur_q;
    logic [2:0]            burst_q;
    logic [4:0]            occ0_q, occ1_q;
    logic [4:0]            occ0_d, occ1_d;
    logic [1:0]            out_valid_q;
    logic                  out_thread_q;
    logic [DATA_WIDTH-1:0] out_data0_q, out_data1_q;

    logic       acc;
    logic [2:0] acc_k;
    logic [4:0] occ_cur, occ_oth;
    logic       load_en;
    logic       issue_en;
    logic [1:0] rd_k;
    logic       switch_req;

    assign acc = wr_wen & ~wr_fStall & ~wr_doFStall;

    always_comb begin
        acc_k = 3'd0;
        case (wr_cnt)
            5'b00010: acc_k = 3'd1;
            5'b00100: acc_k = 3'd2;
            5'b01000: acc_k = 3'd3;
            5'b10000: acc_k = 3'd4;
            default:  acc_k = 3'd0;
        endcase
    end

    assign occ_cur = cur_q ? occ1_q : occ0_q;
    assign occ_oth = cur_q ? occ0_q : occ1_q;

    // Handshake: a slot pair is transferred on any cycle where out_valid != 00 and out_ready = 1;
    // out_valid/out_thread/out_data never change while out_valid != 00 and out_ready = 0, except on flush.
    assign load_en  = (out_valid_q == 2'b00) | out_ready;
    assign issue_en = (state_q == RUN) & ~except & load_en;

    always_comb begin
        rd_k = 2'd0;
        if (issue_en) begin
            rd_k = (occ_cur >= 5'd2) ? 2'd2 : occ_cur[1:0];
        end
    end

    assign switch_req = (state_q == RUN) & (occ_oth != 5'd0) &
                        ((occ_cur == 5'd0) | (burst_q == BURST_MAX));

    // The FIFO freezes both threads' pointers during an except, so neither side is counted then.
    always_comb begin
        occ0_d = occ0_q;
        occ1_d = occ1_q;
        if (except) begin
            if (except_thread) occ1_d = 5'd0;
            else               occ0_d = 5'd0;
        end else begin
            occ0_d = occ0_q + ((acc & ~wr_thread) ? {2'b00, acc_k} : 5'd0)
                            - (~cur_q ? {3'b000, rd_k} : 5'd0);
            occ1_d = occ1_q + ((acc & wr_thread) ? {2'b00, acc_k} : 5'd0)
                            - (cur_q ? {3'b000, rd_k} : 5'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PRIME;
            cur_q        <= 1'b0;
            burst_q      <= 3'd0;
            occ0_q       <= 5'd0;
            occ1_q       <= 5'd0;
            out_valid_q  <= 2'b00;
            out_thread_q <= 1'b0;
            out_data0_q  <= '0;
            out_data1_q  <= '0;
        end else begin
            occ0_q <= occ0_d;
            occ1_q <= occ1_d;
            if (except) begin
                if (except_thread == cur_q) begin
                    state_q <= PRIME;
                    burst_q <= 3'd0;
                end
                if (out_ready || (out_thread_q == except_thread)) begin
                    out_valid_q <= 2'b00;
                end
            end else begin
                if (state_q == PRIME) begin
                    state_q <= RUN;
                end else if (switch_req) begin
                    cur_q   <= ~cur_q;
                    state_q <= PRIME;
                    burst_q <= 3'd0;
                end else if (burst_q != BURST_MAX) begin
                    burst_q <= burst_q + 3'd1;
                end

                if (rd_k != 2'd0) begin
                    out_data0_q  <= rd_data0;
                    out_data1_q  <= rd_data1;
                    out_valid_q  <= {rd_k == 2'd2, 1'b1};
                    out_thread_q <= cur_q;
                end else if (out_ready) begin
                    out_valid_q <= 2'b00;
                end
            end
        end
    end

    assign read_thread = cur_q;
    assign read_cnt    = {rd_k == 2'd2, rd_k == 2'd1, rd_k == 2'd0};
    assign stall       = (state_q == RUN) & ~except & ~load_en;
    assign out_valid   = out_valid_q;
    assign out_thread  = out_thread_q;
    assign out_data0   = out_data0_q;
    assign out_data1   = out_data1_q;
    assign dbg_state   = (state_q == RUN);
    assign dbg_occ0    = occ0_q;
    assign dbg_occ1    = occ1_q;

endmodule
